// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants, write-port payload and write-back source helper.
package wb_regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(0);

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_MEM = 1'b1;

    // Register file write port; en is already qualified as a real commit
    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } rf_wr_t;

    function automatic logic [XLEN-1:0] wb_select(
        input logic            mem_to_reg,
        input logic [XLEN-1:0] load_data,
        input logic [XLEN-1:0] alu_res
    );
        return (mem_to_reg == WB_SRC_MEM) ? load_data : alu_res;
    endfunction

endpackage

// File: rtl/wb_regfile_core.sv
// 31-entry integer register file: one write port, two combinational read
// ports with x0 hardwired to zero and write-first bypass.
module regfile_core
    import wb_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  rf_wr_t                wr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data
);

    // x0 has no storage; entries start at index 1
    logic [XLEN-1:0] regs [1:NREGS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                regs[REG_ADDR_W'(i)] <= '0;
            end
        end else if (wr.en && (wr.addr != ZERO_REG)) begin
            regs[wr.addr] <= wr.data;
        end
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_addr == ZERO_REG) begin
            rs1_data = '0;
        end else if (wr.en && (wr.addr == rs1_addr)) begin
            rs1_data = wr.data;
        end else begin
            rs1_data = regs[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr == ZERO_REG) begin
            rs2_data = '0;
        end else if (wr.en && (wr.addr == rs2_addr)) begin
            rs2_data = wr.data;
        end else begin
            rs2_data = regs[rs2_addr];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: source select, commit qualification, commit counter and
// the integer register file.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       MEMWB_LoadData,
    input  logic [XLEN-1:0]       MEMWB_AluRES,
    input  logic [REG_ADDR_W-1:0] MEMWB_rd,
    input  logic                  MEMWB_WriteBack,
    input  logic                  MEMWB_MemToReg,
    input  logic [REG_ADDR_W-1:0] ID_rs1,
    input  logic [REG_ADDR_W-1:0] ID_rs2,
    output logic [XLEN-1:0]       RF_rs1_data,
    output logic [XLEN-1:0]       RF_rs2_data,
    output logic [XLEN-1:0]       WB_data,
    output logic [CNT_W-1:0]      WB_count
);

    logic              commit;
    rf_wr_t            rf_wr;
    logic [CNT_W-1:0]  count_q;

    assign WB_data = wb_select(MEMWB_MemToReg, MEMWB_LoadData, MEMWB_AluRES);

    // Writes to x0 are dropped entirely and never counted
    assign commit = MEMWB_WriteBack && (MEMWB_rd != ZERO_REG);

    assign rf_wr.en   = commit;
    assign rf_wr.addr = MEMWB_rd;
    assign rf_wr.data = WB_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (commit) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign WB_count = count_q;

    regfile_core u_core (
        .clk      (clk),
        .rst      (rst),
        .wr       (rf_wr),
        .rs1_addr (ID_rs1),
        .rs2_addr (ID_rs2),
        .rs1_data (RF_rs1_data),
        .rs2_data (RF_rs2_data)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, reset and
// counter-wrap sequences, then random traffic against an array model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ld, alu;
    logic [4:0]  rd, rs1, rs2;
    logic        we, m2r;
    logic [31:0] rs1_data, rs2_data, wb_data, wb_count;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] mdl_mem [32];
    logic [31:0] mdl_cnt;

    typedef struct {
        logic        we;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] ld;
        logic [31:0] alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_wb;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [11];

    wb_regfile dut (
        .clk             (clk),
        .rst             (rst),
        .MEMWB_LoadData  (ld),
        .MEMWB_AluRES    (alu),
        .MEMWB_rd        (rd),
        .MEMWB_WriteBack (we),
        .MEMWB_MemToReg  (m2r),
        .ID_rs1          (rs1),
        .ID_rs2          (rs2),
        .RF_rs1_data     (rs1_data),
        .RF_rs2_data     (rs2_data),
        .WB_data         (wb_data),
        .WB_count        (wb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdl_wb(input logic sel, input logic [31:0] l, input logic [31:0] a);
        return sel ? l : a;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [4:0] addr);
        logic [31:0] v;
        if (addr == 5'd0) v = 32'h0;
        else if (we && rd == addr) v = mdl_wb(m2r, ld, alu);
        else v = mdl_mem[addr];
        return v;
    endfunction

    function automatic void mdl_clear();
        for (int i = 0; i < 32; i++) mdl_mem[i] = 32'h0;
        mdl_cnt = 32'h0;
    endfunction

    // One cycle: drive after the falling edge, check, then let the rising edge commit
    task automatic step(input logic w, input logic s, input logic [4:0] d,
                        input logic [31:0] l, input logic [31:0] a,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input bit use_exp, input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] ew, input logic [31:0] ec, input string tag);
        @(negedge clk);
        we = w; m2r = s; rd = d; ld = l; alu = a; rs1 = r1; rs2 = r2;
        #1;
        if (use_exp) begin
            chk({tag, " rs1"}, rs1_data, e1);
            chk({tag, " rs2"}, rs2_data, e2);
            chk({tag, " wb"},  wb_data,  ew);
            chk({tag, " cnt"}, wb_count, ec);
        end else begin
            chk({tag, " rs1"}, rs1_data, mdl_read(r1));
            chk({tag, " rs2"}, rs2_data, mdl_read(r2));
            chk({tag, " wb"},  wb_data,  mdl_wb(s, l, a));
            chk({tag, " cnt"}, wb_count, mdl_cnt);
        end
        @(posedge clk);
        if (w && d != 5'd0) begin
            mdl_mem[d] = mdl_wb(s, l, a);
            mdl_cnt    = mdl_cnt + 32'd1;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 5'd7, 32'h11112222, 32'h33334444, 5'd7, 5'd0, 32'h11112222, 32'h0, 32'h11112222, 32'd0};
        tbl[1]  = '{1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7, 32'h11112222, 32'h11112222, 32'h0, 32'd1};
        tbl[2]  = '{1'b1, 1'b0, 5'd7, 32'h11112222, 32'h33334444, 5'd0, 5'd7, 32'h0, 32'h33334444, 32'h33334444, 32'd1};
        tbl[3]  = '{1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0, 32'h33334444, 32'h0, 32'h0, 32'd2};
        tbl[4]  = '{1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd7, 32'h0, 32'h33334444, 32'hFFFFFFFF, 32'd2};
        tbl[5]  = '{1'b0, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd2};
        tbl[6]  = '{1'b1, 1'b0, 5'd9, 32'h0, 32'h01010101, 5'd3, 5'd3, 32'h0, 32'h0, 32'h01010101, 32'd2};
        tbl[7]  = '{1'b1, 1'b0, 5'd9, 32'h0, 32'hCAFEF00D, 5'd9, 5'd9, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'd3};
        tbl[8]  = '{1'b1, 1'b1, 5'd3, 32'hAAAA5555, 32'h0, 5'd9, 5'd3, 32'hCAFEF00D, 32'hAAAA5555, 32'hAAAA5555, 32'd4};
        tbl[9]  = '{1'b0, 1'b0, 5'd3, 32'h12345678, 32'h12345678, 5'd3, 5'd9, 32'hAAAA5555, 32'hCAFEF00D, 32'h12345678, 32'd5};
        tbl[10] = '{1'b0, 1'b0, 5'd3, 32'h0, 32'h0, 5'd3, 5'd0, 32'hAAAA5555, 32'h0, 32'h0, 32'd5};

        rst = 1'b1; we = 1'b0; m2r = 1'b0; rd = '0; ld = '0; alu = '0; rs1 = '0; rs2 = '0;
        mdl_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state of every register
        for (int i = 0; i < 32; i += 2) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(i + 1), 1'b1,
                 32'h0, 32'h0, 32'h0, 32'h0, "reset_state");
        end

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].we, tbl[i].m2r, tbl[i].rd, tbl[i].ld, tbl[i].alu, tbl[i].rs1, tbl[i].rs2,
                 1'b1, tbl[i].e_rs1, tbl[i].e_rs2, tbl[i].e_wb, tbl[i].e_cnt, $sformatf("vec%0d", i));
        end

        // Asynchronous reset between edges clears storage and count at once
        step(1'b1, 1'b0, 5'd5, 32'h0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 0, 0, 0, 0, "wr_x5");
        @(negedge clk);
        we = 1'b0; rs1 = 5'd5; rs2 = 5'd0;
        #1 chk("pre_rst x5", rs1_data, 32'hDEADBEEF);
        #1 rst = 1'b1;
        #1 chk("async_rst x5", rs1_data, 32'h0);
        chk("async_rst cnt", wb_count, 32'h0);
        we = 1'b1; m2r = 1'b0; rd = 5'd5; alu = 32'h00000077;
        #1 chk("rst_bypass x5", rs1_data, 32'h00000077);
        @(posedge clk);
        #1 we = 1'b0;
        #1 chk("rst_commit_lost x5", rs1_data, 32'h0);
        chk("rst_commit_lost cnt", wb_count, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mdl_clear();
        step(1'b1, 1'b0, 5'd5, 32'h0, 32'h00000055, 5'd0, 5'd0, 1'b0, 0, 0, 0, 0, "post_rst_wr");
        step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5, 1'b1,
             32'h00000055, 32'h00000055, 32'h0, 32'd1, "post_rst_rd");

        // Counter wrap via backdoor preload
        @(negedge clk);
        dut.count_q = 32'hFFFF_FFFE;
        mdl_cnt = 32'hFFFF_FFFE;
        step(1'b1, 1'b0, 5'd1, 32'h0, 32'h1, 5'd0, 5'd0, 1'b0, 0, 0, 0, 0, "wrap_a");
        step(1'b1, 1'b0, 5'd2, 32'h0, 32'h2, 5'd0, 5'd0, 1'b1,
             32'h0, 32'h0, 32'h2, 32'hFFFF_FFFF, "wrap_b");
        step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd2, 1'b1,
             32'h1, 32'h2, 32'h0, 32'h0, "wrap_c");

        // Random traffic against the array model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] d, a, b;
            d = 5'($urandom_range(0, 31));
            a = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            b = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d, $urandom, $urandom,
                 a, b, 1'b0, 0, 0, 0, 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
